modexp_core: RTL and testbench

//  Parametrised modular exponentiation engine: o_a_pow_d = i_a^i_d mod i_n for WIDTH-bit operands.

---
 rtl/modexp_core.sv | 203 ++++++++++++++++++++
 tb/tb_modexp_core.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_core.sv
// modexp_core: WIDTH-bit modular exponentiation, a^d mod n.
// Montgomery pre-scaling, then right-to-left binary exponentiation.
module modexp_core #(
    parameter int WIDTH      = 256,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_d,
    output logic             o_finished,
    output logic             o_busy,
    output logic             o_error
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH);
    localparam logic [CW-1:0] PREP_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MONT,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   ds_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   t_q;
    logic [WIDTH-1:0]   xa_q;
    logic [WIDTH-1:0]   xb_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH+1:0]   ra_q;
    logic [WIDTH+1:0]   rb_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      k_q;
    logic               fin_q;
    logic               busy_q;
    logic               err_q;

    logic [WIDTH:0]     dbl;
    logic [WIDTH-1:0]   prep_d;
    logic [WIDTH+1:0]   n_ext;
    logic [WIDTH+1:0]   sa;
    logic [WIDTH+1:0]   sb;
    logic [WIDTH+1:0]   ra_d;
    logic [WIDTH+1:0]   rb_d;
    logic [WIDTH+1:0]   ra_red;
    logic [WIDTH+1:0]   rb_red;
    logic [WIDTH-1:0]   m_d;
    logic [CW-1:0]      e_w;
    logic               last_bit;
    logic               bad_n;

    // Pre-scaling step: doubling with a single conditional subtract.
    always_comb begin
        dbl    = {t_q, 1'b0};
        prep_d = dbl[WIDTH-1:0];
        if (dbl >= {1'b0, n_q}) begin
            prep_d = WIDTH'(dbl - {1'b0, n_q});
        end
    end

    // Two bit-serial Montgomery units: A = mont(m,t), B = mont(t,t).
    always_comb begin
        n_ext  = {2'b00, n_q};
        sa     = ra_q + (xa_q[0] ? {2'b00, t_q} : '0);
        sa     = sa + (sa[0] ? n_ext : '0);
        ra_d   = sa >> 1;
        sb     = rb_q + (xb_q[0] ? {2'b00, t_q} : '0);
        sb     = sb + (sb[0] ? n_ext : '0);
        rb_d   = sb >> 1;
        ra_red = (ra_q >= n_ext) ? ra_q - n_ext : ra_q;
        rb_red = (rb_q >= n_ext) ? rb_q - n_ext : rb_q;
    end

    // Exponent length, exit test, multiply select and operand check.
    always_comb begin
        e_w = CNT_LAST;
        if (EARLY_EXIT) begin
            e_w = CW'(1);
            for (int i = 0; i < WIDTH; i++) begin
                if (d_q[i]) begin
                    e_w = CW'(i + 1);
                end
            end
        end
        last_bit = (k_q + CW'(1)) == e_w;
        m_d      = ds_q[0] ? ra_q[WIDTH-1:0] : m_q;
        bad_n    = !i_n[0] || (i_n < WIDTH'(3));
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            d_q     <= '0;
            ds_q    <= '0;
            m_q     <= '0;
            t_q     <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
            res_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        n_q    <= i_n;
                        d_q    <= i_d;
                        ds_q   <= i_d;
                        m_q    <= WIDTH'(1);
                        t_q    <= i_a;
                        cnt_q  <= '0;
                        k_q    <= '0;
                        busy_q <= 1'b1;
                        if (bad_n) begin
                            state_q <= S_DONE;
                            fin_q   <= 1'b1;
                            err_q   <= 1'b1;
                            res_q   <= '0;
                        end else begin
                            state_q <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    t_q <= prep_d;
                    if (cnt_q == PREP_LAST) begin
                        state_q <= S_MONT;
                        cnt_q   <= '0;
                        xa_q    <= m_q;
                        xb_q    <= prep_d;
                        ra_q    <= '0;
                        rb_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_MONT: begin
                    if (cnt_q == CNT_LAST) begin
                        ra_q    <= ra_red;
                        rb_q    <= rb_red;
                        state_q <= S_CALC;
                    end else begin
                        ra_q  <= ra_d;
                        rb_q  <= rb_d;
                        xa_q  <= xa_q >> 1;
                        xb_q  <= xb_q >> 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_CALC: begin
                    m_q  <= m_d;
                    t_q  <= rb_q[WIDTH-1:0];
                    k_q  <= k_q + CW'(1);
                    ds_q <= ds_q >> 1;
                    if (last_bit) begin
                        state_q <= S_DONE;
                        fin_q   <= 1'b1;
                        res_q   <= m_d;
                    end else begin
                        state_q <= S_MONT;
                        cnt_q   <= '0;
                        xa_q    <= m_d;
                        xb_q    <= rb_q[WIDTH-1:0];
                        ra_q    <= '0;
                        rb_q    <= '0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    fin_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_a_pow_d  = res_q;
    assign o_finished = fin_q;
    assign o_busy     = busy_q;
    assign o_error    = err_q;

endmodule

// File: tb/tb_modexp_core.sv
// tb_modexp_core: scoreboard bench for modexp_core.
// Units: 0 = W8/full, 1 = W8/early exit, 2 = W256/early exit.
module tb_modexp_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   start;
    logic [2:0]   fin;
    logic [2:0]   busy;
    logic [2:0]   err;
    logic [255:0] a_bus;
    logic [255:0] d_bus;
    logic [255:0] n_bus;
    logic [7:0]   r0;
    logic [7:0]   r1;
    logic [255:0] r2;

    typedef struct {
        logic [255:0] res;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   vecs = 0;
    int   bad  = 0;

    always #5 clk = ~clk;

    modexp_core #(.WIDTH(8), .EARLY_EXIT(1'b0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]),
        .i_a(a_bus[7:0]), .i_d(d_bus[7:0]), .i_n(n_bus[7:0]),
        .o_a_pow_d(r0), .o_finished(fin[0]),
        .o_busy(busy[0]), .o_error(err[0])
    );

    modexp_core #(.WIDTH(8), .EARLY_EXIT(1'b1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]),
        .i_a(a_bus[7:0]), .i_d(d_bus[7:0]), .i_n(n_bus[7:0]),
        .o_a_pow_d(r1), .o_finished(fin[1]),
        .o_busy(busy[1]), .o_error(err[1])
    );

    modexp_core #(.WIDTH(256), .EARLY_EXIT(1'b1)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]),
        .i_a(a_bus), .i_d(d_bus), .i_n(n_bus),
        .o_a_pow_d(r2), .o_finished(fin[2]),
        .o_busy(busy[2]), .o_error(err[2])
    );

    // Plain square-and-multiply with full-width products.
    function automatic logic [255:0] ref_pow(input logic [255:0] a,
                                              input logic [255:0] d,
                                              input logic [255:0] n);
        logic [511:0] r;
        logic [511:0] b;
        logic [511:0] nn;
        nn = {256'b0, n};
        r  = 512'd1 % nn;
        b  = {256'b0, a} % nn;
        for (int i = 0; i < 256; i++) begin
            if (d[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[255:0];
    endfunction

    function automatic int ref_lat(input int w, input bit ee,
                                   input logic [255:0] d, input logic e);
        int ex;
        if (e) return 1;
        ex = w;
        if (ee) begin
            ex = 1;
            for (int i = 0; i < w; i++) if (d[i]) ex = i + 1;
        end
        return w + ex * (w + 2) + 1;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drive one start cycle and record what the operation must produce.
    task automatic launch(input int u, input logic [255:0] a,
                          input logic [255:0] d, input logic [255:0] n);
        exp_t e;
        int   w;
        bit   ee;
        w     = (u == 2) ? 256 : 8;
        ee    = (u != 0);
        e.err = !n[0] || (n < 3);
        e.res = e.err ? 256'd0 : ref_pow(a, d, n);
        e.lat = ref_lat(w, ee, d, e.err);
        sbq.push_back(e);
        a_bus    = a;
        d_bus    = d;
        n_bus    = n;
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    // Wait for o_finished (bounded); optional start poke while busy.
    task automatic wait_done(input int u, input int poke,
                             output logic [255:0] res, output logic e,
                             output int lat, output bit bok,
                             output logic bafter, output bit to);
        int cyc;
        int lim;
        bit done;
        cyc  = 1;
        done = 0;
        bok  = 1;
        to   = 0;
        lim  = sbq[0].lat + 20;
        while (!done) begin
            if (busy[u] !== 1'b1) bok = 0;
            if (fin[u] === 1'b1) done = 1;
            else if (cyc > lim) begin
                to   = 1;
                done = 1;
            end else begin
                if (cyc == poke) begin
                    start[u] = 1'b1;
                    a_bus    = ~a_bus;
                    d_bus    = ~d_bus;
                end
                @(negedge clk);
                start[u] = 1'b0;
                cyc++;
            end
        end
        lat = cyc;
        e   = err[u];
        res = (u == 0) ? {248'b0, r0} :
              (u == 1) ? {248'b0, r1} : r2;
        @(negedge clk);
        bafter = busy[u];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = '0;
        a_bus = '0;
        d_bus = '0;
        n_bus = '0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({fin, busy, err} !== 9'd0) begin
            bad++;
            $display("FAIL reset_flags got %b want 0", {fin, busy, err});
        end
        vecs++;
        if ({r0, r1} !== 16'd0 || r2 !== 256'd0) begin
            bad++;
            $display("FAIL reset_res got %h %h %h want 0", r0, r1, r2);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_w8();
        int tu[11] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};
        int ta[11] = '{5, 5, 5, 7, 2, 0, 0, 9, 2, 5, 200};
        int td[11] = '{3, 3, 0, 0, 5, 0, 9, 1, 200, 3, 255};
        int tn[11] = '{33, 33, 33, 32, 35, 35, 35, 35, 3, 1, 255};
        logic [255:0] res;
        logic         e;
        logic         ba;
        int           lat;
        bit           bok;
        bit           to;
        exp_t         x;
        int           u;
        int           n;
        for (int i = 0; i < 19; i++) begin
            if (i < 11) begin
                u = tu[i];
                launch(u, 256'(ta[i]), 256'(td[i]), 256'(tn[i]));
            end else begin
                u = i % 2;
                n = $urandom_range(3, 255) | 1;
                launch(u, 256'($urandom_range(0, n - 1)),
                       256'($urandom_range(0, 255)), 256'(n));
            end
            wait_done(u, -1, res, e, lat, bok, ba, to);
            x = sbq.pop_front();
            vecs++;
            if (to) begin
                bad++;
                $display("FAIL w8[%0d] timeout got none want cycle %0d",
                         i, x.lat);
            end else begin
                vecs++;
                if (res !== x.res) begin
                    bad++;
                    $display("FAIL w8[%0d] result got %0d want %0d",
                             i, res, x.res);
                end
                vecs++;
                if (e !== x.err) begin
                    bad++;
                    $display("FAIL w8[%0d] error got %b want %b",
                             i, e, x.err);
                end
                vecs++;
                if (lat !== x.lat) begin
                    bad++;
                    $display("FAIL w8[%0d] latency got %0d want %0d",
                             i, lat, x.lat);
                end
                vecs++;
                if (!bok || ba !== 1'b0) begin
                    bad++;
                    $display("FAIL w8[%0d] busy got %b/%b want 1/0",
                             i, bok, ba);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [255:0] res;
        logic         e;
        logic         ba;
        int           lat;
        bit           bok;
        bit           to;
        exp_t         x;
        launch(0, 256'd5, 256'd3, 256'd33);
        wait_done(0, 40, res, e, lat, bok, ba, to);
        x = sbq.pop_front();
        vecs++;
        if (to || res !== x.res || lat !== x.lat || !bok) begin
            bad++;
            $display("FAIL busy_ignore got %0d@%0d want %0d@%0d",
                     res, lat, x.res, x.lat);
        end
        vecs++;
        if (ba !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_idle got %b want 0", ba);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] res;
        logic         e;
        logic         ba;
        int           lat;
        bit           bok;
        bit           to;
        exp_t         x;
        launch(1, 256'd7, 256'd13, 256'd221);
        wait_done(1, -1, res, e, lat, bok, ba, to);
        x = sbq.pop_front();
        vecs++;
        if (to || res !== x.res || lat !== x.lat) begin
            bad++;
            $display("FAIL b2b_first got %0d@%0d want %0d@%0d",
                     res, lat, x.res, x.lat);
        end
        launch(1, 256'd3, 256'd6, 256'd101);
        wait_done(1, -1, res, e, lat, bok, ba, to);
        x = sbq.pop_front();
        vecs++;
        if (to || res !== x.res || lat !== x.lat || !bok) begin
            bad++;
            $display("FAIL b2b_second got %0d@%0d want %0d@%0d",
                     res, lat, x.res, x.lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] res;
        logic         e;
        logic         ba;
        int           lat;
        bit           bok;
        bit           to;
        bit           seen;
        exp_t         x;
        launch(0, 256'd2, 256'd5, 256'd35);
        x    = sbq.pop_front();
        seen = 0;
        for (int c = 1; c < 30; c++) begin
            if (fin[0] === 1'b1) seen = 1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({fin, busy, err} !== 9'd0) begin
            bad++;
            $display("FAIL rst_mid_flags got %b want 0", {fin, busy, err});
        end
        vecs++;
        if ({r0, r1} !== 16'd0 || r2 !== 256'd0) begin
            bad++;
            $display("FAIL rst_mid_res got %h %h %h want 0", r0, r1, r2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (fin !== 3'd0 || busy !== 3'd0) seen = 1;
            @(negedge clk);
        end
        vecs++;
        if (seen) begin
            bad++;
            $display("FAIL rst_mid_quiet got activity want none");
        end
        launch(0, 256'd2, 256'd5, 256'd35);
        wait_done(0, -1, res, e, lat, bok, ba, to);
        x = sbq.pop_front();
        vecs++;
        if (to || res !== x.res || e !== 1'b0 || lat !== x.lat) begin
            bad++;
            $display("FAIL rst_mid_restart got %0d@%0d want %0d@%0d",
                     res, lat, x.res, x.lat);
        end
    endtask

    task automatic test_w256();
        logic [255:0] res;
        logic [255:0] a;
        logic [255:0] d;
        logic [255:0] n;
        logic         e;
        logic         ba;
        int           lat;
        bit           bok;
        bit           to;
        exp_t         x;
        for (int i = 0; i < 11; i++) begin
            n = rand256() | {1'b1, 255'b0} | 256'd1;
            if (i == 2) n = '1;
            a = rand256() % n;
            d = 256'($urandom_range(2, 63));
            if (i == 0) d = 256'd1;
            if (i == 1) a = '0;
            launch(2, a, d, n);
            wait_done(2, -1, res, e, lat, bok, ba, to);
            x = sbq.pop_front();
            vecs++;
            if (to) begin
                bad++;
                $display("FAIL w256[%0d] timeout got none want cycle %0d",
                         i, x.lat);
            end else begin
                vecs++;
                if (res !== x.res) begin
                    bad++;
                    $display("FAIL w256[%0d] result got %h want %h",
                             i, res, x.res);
                end
                vecs++;
                if (e !== 1'b0 || lat !== x.lat || !bok) begin
                    bad++;
                    $display("FAIL w256[%0d] status got %b@%0d want 0@%0d",
                             i, e, lat, x.lat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_w8();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_w256();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
